// File: rtl/hazard_detect_pkg.sv
// Shared pipeline defines: opcodes, hazard codes, scoreboard entry types, opcode decode.
package hazard_detect_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned OPC_W  = 7;
    localparam int unsigned HZ_W   = 3;

    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [HZ_W-1:0] HZ_NONE    = 3'd0;
    localparam logic [HZ_W-1:0] HZ_EX_RS1  = 3'd1;
    localparam logic [HZ_W-1:0] HZ_EX_RS2  = 3'd2;
    localparam logic [HZ_W-1:0] HZ_MEM_RS1 = 3'd3;
    localparam logic [HZ_W-1:0] HZ_MEM_RS2 = 3'd4;

    // Register-usage summary of one opcode.
    typedef struct packed {
        logic uses_rs1;
        logic uses_rs2;
        logic writes_rd;
        logic is_load;
    } op_dec_t;

    // Producer identity; this is all the distance-2 slot needs.
    typedef struct packed {
        logic              valid;
        logic              wen;
        logic [REG_AW-1:0] rd;
    } sb_tag_t;

    // Distance-1 slot additionally remembers whether the producer is a load.
    typedef struct packed {
        sb_tag_t tag;
        logic    is_load;
    } sb_entry_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } hz_state_e;

    // Which register fields an opcode actually reads/writes.
    function automatic op_dec_t decode_op(input logic [OPC_W-1:0] op);
        op_dec_t d;
        d.uses_rs1  = !((op == OPC_LUI) || (op == OPC_AUIPC) || (op == OPC_JAL));
        d.uses_rs2  = (op == OPC_OP) || (op == OPC_STORE) || (op == OPC_BRANCH);
        d.writes_rd = !((op == OPC_STORE) || (op == OPC_BRANCH));
        d.is_load   = (op == OPC_LOAD);
        return d;
    endfunction

    // A used, non-x0 source depends on a live, writing producer.
    function automatic logic src_match(input sb_tag_t t, input logic [REG_AW-1:0] src,
                                       input logic used);
        return t.valid && t.wen && (t.rd != '0) && used && (src == t.rd);
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Two-deep shift register of in-flight destinations with source comparators.
module hazard_scoreboard
    import hazard_detect_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  sb_entry_t         push_i,
    input  logic [REG_AW-1:0] rs1_i,
    input  logic [REG_AW-1:0] rs2_i,
    input  logic              use_rs1_i,
    input  logic              use_rs2_i,
    output logic              e1_rs1_o,
    output logic              e1_rs2_o,
    output logic              e2_rs1_o,
    output logic              e2_rs2_o,
    output logic              e1_load_o
);

    sb_entry_t e1_q;
    sb_tag_t   e2_q;

    // Every cycle advances the pipe; a bubble is pushed as an all-zero entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e1_q <= '0;
            e2_q <= '0;
        end else begin
            e2_q <= e1_q.tag;
            e1_q <= push_i;
        end
    end

    assign e1_rs1_o  = src_match(e1_q.tag, rs1_i, use_rs1_i);
    assign e1_rs2_o  = src_match(e1_q.tag, rs2_i, use_rs2_i);
    assign e2_rs1_o  = src_match(e2_q, rs1_i, use_rs1_i);
    assign e2_rs2_o  = src_match(e2_q, rs2_i, use_rs2_i);
    assign e1_load_o = e1_q.tag.valid && e1_q.is_load;

endmodule

// File: rtl/hazard_detect.sv
// Decode-side hazard detection: scoreboard lookup, registered hazard codes, load-use stall.
module hazard_detect
    import hazard_detect_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [OPC_W-1:0]  id_op,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              flush,
    output logic              is_hazard1,
    output logic              is_hazard2,
    output logic [HZ_W-1:0]   hazard_reg1,
    output logic [HZ_W-1:0]   hazard_reg2,
    output logic              dual_src1,
    output logic              dual_src2,
    output logic              stall,
    output logic [OPC_W-1:0]  op_out
);

    hz_state_e        state_q, state_d;
    op_dec_t          dec;
    sb_entry_t        push;
    logic             e1_rs1, e1_rs2, e2_rs1, e2_rs2, e1_load;
    logic             load_use, issue;
    logic             is_hazard1_q, is_hazard1_d, is_hazard2_q, is_hazard2_d;
    logic [HZ_W-1:0]  hazard_reg1_q, hazard_reg1_d, hazard_reg2_q, hazard_reg2_d;
    logic             dual_src1_q, dual_src1_d, dual_src2_q, dual_src2_d;
    logic [OPC_W-1:0] op_out_q, op_out_d;

    assign dec = decode_op(id_op);

    hazard_scoreboard u_sb (
        .clk       (clk),
        .reset     (reset),
        .push_i    (push),
        .rs1_i     (id_rs1),
        .rs2_i     (id_rs2),
        .use_rs1_i (dec.uses_rs1),
        .use_rs2_i (dec.uses_rs2),
        .e1_rs1_o  (e1_rs1),
        .e1_rs2_o  (e1_rs2),
        .e2_rs1_o  (e2_rs1),
        .e2_rs2_o  (e2_rs2),
        .e1_load_o (e1_load)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    // Stall decision, next state, scoreboard push and hazard code generation.
    // ST_STALL marks the re-evaluation cycle after a bubble, so it can never stall again.
    always_comb begin
        state_d       = state_q;
        stall         = 1'b0;
        push          = '0;
        is_hazard1_d  = 1'b0;
        is_hazard2_d  = 1'b0;
        hazard_reg1_d = HZ_NONE;
        hazard_reg2_d = HZ_NONE;
        dual_src1_d   = 1'b0;
        dual_src2_d   = 1'b0;
        op_out_d      = '0;

        load_use = id_valid && e1_load && (e1_rs1 || e1_rs2) && (state_q == ST_RUN);
        stall    = load_use && !flush;
        issue    = id_valid && !flush && !stall;

        case (state_q)
            ST_RUN:   if (stall) state_d = ST_STALL;
            ST_STALL: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase

        if (issue) begin
            push.tag.valid = 1'b1;
            push.tag.wen   = dec.writes_rd;
            push.tag.rd    = id_rd;
            push.is_load   = dec.is_load;
            op_out_d       = id_op;

            if (e1_rs1) begin
                is_hazard1_d  = 1'b1;
                hazard_reg1_d = HZ_EX_RS1;
            end else if (e1_rs2) begin
                is_hazard1_d  = 1'b1;
                hazard_reg1_d = HZ_EX_RS2;
            end
            dual_src1_d = e1_rs1 && e1_rs2;

            if (e2_rs1) begin
                is_hazard2_d  = 1'b1;
                hazard_reg2_d = HZ_MEM_RS1;
            end else if (e2_rs2) begin
                is_hazard2_d  = 1'b1;
                hazard_reg2_d = HZ_MEM_RS2;
            end
            dual_src2_d = e2_rs1 && e2_rs2;
        end
    end

    // Output registers sampled by the forwarding stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            is_hazard1_q  <= 1'b0;
            is_hazard2_q  <= 1'b0;
            hazard_reg1_q <= HZ_NONE;
            hazard_reg2_q <= HZ_NONE;
            dual_src1_q   <= 1'b0;
            dual_src2_q   <= 1'b0;
            op_out_q      <= '0;
        end else begin
            is_hazard1_q  <= is_hazard1_d;
            is_hazard2_q  <= is_hazard2_d;
            hazard_reg1_q <= hazard_reg1_d;
            hazard_reg2_q <= hazard_reg2_d;
            dual_src1_q   <= dual_src1_d;
            dual_src2_q   <= dual_src2_d;
            op_out_q      <= op_out_d;
        end
    end

    assign is_hazard1  = is_hazard1_q;
    assign is_hazard2  = is_hazard2_q;
    assign hazard_reg1 = hazard_reg1_q;
    assign hazard_reg2 = hazard_reg2_q;
    assign dual_src1   = dual_src1_q;
    assign dual_src2   = dual_src2_q;
    assign op_out      = op_out_q;

endmodule
